// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the riscv memory arbiter slice.
package riscv_mem_pkg;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CNT_W = 4;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant history lives in the parent.
module rr_arb2
    import riscv_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                // On contention the port that was not served last wins.
                if (last_grant == PORT_D) grant[PORT_F] = 1'b1;
                else                      grant[PORT_D] = 1'b1;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares the single fixed-latency RAM port between instruction fetch (F)
// and the load/store unit (D), one transaction in flight at a time.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int AW          = riscv_mem_pkg::AW,
    parameter int DW          = riscv_mem_pkg::DW,
    parameter int RAM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req_valid,
    output logic          f_req_ready,
    input  logic [AW-1:0] f_adress,
    output logic          f_rsp_valid,
    output logic [DW-1:0] f_rsp_data,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic [AW-1:0] d_adress,
    input  logic          d_we,
    input  logic [DW-1:0] d_wdata,
    output logic          d_rsp_valid,
    output logic [DW-1:0] d_rsp_data,
    output logic [AW-1:0] ram_adress,
    output logic [DW-1:0] data_out_ram,
    output logic          ram_enable_write,
    input  logic [DW-1:0] data_in_ram
);

    // Handshake: a request is accepted in the cycle where valid and ready are
    // both high; ready is combinational, only asserted in IDLE, and never
    // depends on the other port's response. Each accept yields one rsp pulse.

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             owner;
    logic             we_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;
    logic             arb_en;

    assign arb_en = rst_n && (state == IDLE);

    rr_arb2 u_rr_arb2 (
        .req        ({d_req_valid, f_req_valid}),
        .last_grant (last_grant),
        .enable     (arb_en),
        .grant      (grant)
    );

    assign f_req_ready = grant[PORT_F];
    assign d_req_ready = grant[PORT_D];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant != 2'b00) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant       <= PORT_D;
            owner            <= PORT_F;
            we_q             <= 1'b0;
            cnt              <= '0;
            ram_adress       <= '0;
            data_out_ram     <= '0;
            ram_enable_write <= 1'b0;
            f_rsp_valid      <= 1'b0;
            f_rsp_data       <= '0;
            d_rsp_valid      <= 1'b0;
            d_rsp_data       <= '0;
        end else begin
            f_rsp_valid      <= 1'b0;
            d_rsp_valid      <= 1'b0;
            ram_enable_write <= 1'b0;
            case (state)
                IDLE: begin
                    // Request fields are sampled here only; later changes are ignored.
                    if (grant[PORT_D]) begin
                        ram_adress       <= d_adress;
                        data_out_ram     <= d_wdata;
                        ram_enable_write <= d_we;
                        we_q             <= d_we;
                        owner            <= PORT_D;
                        last_grant       <= PORT_D;
                    end else if (grant[PORT_F]) begin
                        ram_adress <= f_adress;
                        we_q       <= 1'b0;
                        owner      <= PORT_F;
                        last_grant <= PORT_F;
                    end
                end
                ISSUE: cnt <= CNT_W'(RAM_LATENCY - 1);
                WAIT: begin
                    if (cnt == '0) begin
                        if (owner == PORT_D) begin
                            d_rsp_data  <= we_q ? '0 : data_in_ram;
                            d_rsp_valid <= 1'b1;
                        end else begin
                            f_rsp_data  <= data_in_ram;
                            f_rsp_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: two lanes (RAM_LATENCY 1 and 3), each with a
// RAM model, a request driver with a reference model, and a response monitor.
module tb_riscv_mem_arbiter;
    import riscv_mem_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        int          at;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        int          at;
    } ram_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane %0d cycle %0d: got %h expected %h", name, lane, cyc, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : lane
        localparam int L = (gi == 0) ? 1 : 3;

        logic        rst_n = 1'b1;
        logic        f_req_valid = 1'b0;
        logic        f_req_ready;
        logic [31:0] f_adress = '0;
        logic        f_rsp_valid;
        logic [31:0] f_rsp_data;
        logic        d_req_valid = 1'b0;
        logic        d_req_ready;
        logic [31:0] d_adress = '0;
        logic        d_we = 1'b0;
        logic [31:0] d_wdata = '0;
        logic        d_rsp_valid;
        logic [31:0] d_rsp_data;
        logic [31:0] ram_adress;
        logic [31:0] data_out_ram;
        logic        ram_enable_write;
        logic [31:0] data_in_ram;

        riscv_mem_arbiter #(.AW(32), .DW(32), .RAM_LATENCY(L)) dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .f_req_valid      (f_req_valid),
            .f_req_ready      (f_req_ready),
            .f_adress         (f_adress),
            .f_rsp_valid      (f_rsp_valid),
            .f_rsp_data       (f_rsp_data),
            .d_req_valid      (d_req_valid),
            .d_req_ready      (d_req_ready),
            .d_adress         (d_adress),
            .d_we             (d_we),
            .d_wdata          (d_wdata),
            .d_rsp_valid      (d_rsp_valid),
            .d_rsp_data       (d_rsp_data),
            .ram_adress       (ram_adress),
            .data_out_ram     (data_out_ram),
            .ram_enable_write (ram_enable_write),
            .data_in_ram      (data_in_ram)
        );

        // RAM: read data for the presented address is valid L cycles later.
        logic [31:0] ram_mem [0:63];
        logic [31:0] rd_pipe [0:L-1];
        always @(posedge clk) begin
            if (ram_enable_write) ram_mem[ram_adress[5:0]] <= data_out_ram;
            rd_pipe[0] <= ram_mem[ram_adress[5:0]];
            for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign data_in_ram = rd_pipe[L-1];

        // Reference model state
        logic [31:0] model_mem [0:63];
        logic        model_last = PORT_D;
        int          free_at = 0;
        rsp_t        exp_f_q[$];
        rsp_t        exp_d_q[$];
        ram_t        ram_q[$];
        logic [31:0] f_hold = '0;
        logic [31:0] d_hold = '0;
        int          nf = 0;
        int          nd = 0;
        logic        mon_on = 1'b0;
        logic        done = 1'b0;
        rsp_t        fe, de;
        ram_t        re;

        task automatic step(input logic fv, input logic [31:0] fa, input logic dv, input logic [31:0] da,
                            input logic dwe, input logic [31:0] dwd, output logic f_acc, output logic d_acc);
            logic ef, ed;
            @(negedge clk);
            f_req_valid = fv;
            f_adress    = fa;
            d_req_valid = dv;
            d_adress    = da;
            d_we        = dwe;
            d_wdata     = dwd;
            #1;
            ef = rst_n && (cyc >= free_at) && fv && (!dv || model_last == PORT_D);
            ed = rst_n && (cyc >= free_at) && dv && (!fv || model_last == PORT_F);
            chk("f_req_ready", gi, 32'(f_req_ready), 32'(ef));
            chk("d_req_ready", gi, 32'(d_req_ready), 32'(ed));
            if (ef) begin
                model_last = PORT_F;
                free_at    = cyc + L + 3;
                exp_f_q.push_back('{data: model_mem[fa[5:0]], at: cyc + L + 2});
                ram_q.push_back('{addr: fa, wdata: 32'd0, we: 1'b0, at: cyc + 1});
            end else if (ed) begin
                model_last = PORT_D;
                free_at    = cyc + L + 3;
                if (dwe) begin
                    model_mem[da[5:0]] = dwd;
                    exp_d_q.push_back('{data: 32'd0, at: cyc + L + 2});
                end else begin
                    exp_d_q.push_back('{data: model_mem[da[5:0]], at: cyc + L + 2});
                end
                ram_q.push_back('{addr: da, wdata: dwd, we: dwe, at: cyc + 1});
            end
            f_acc = ef;
            d_acc = ed;
        endtask

        task automatic idle();
            logic a, b;
            step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, a, b);
        endtask

        task automatic req(input logic is_d, input logic [31:0] addr, input logic we, input logic [31:0] wd);
            logic a, b;
            logic got;
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                step(!is_d, addr, is_d, addr, we, wd, a, b);
                got = is_d ? b : a;
            end
            if (!got) begin
                errors++;
                $display("FAIL req_timeout lane %0d: request at %h not accepted", gi, addr);
            end
        endtask

        task automatic do_reset();
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            mon_on = 1'b1;
            exp_f_q.delete();
            exp_d_q.delete();
            ram_q.delete();
            model_last = PORT_D;
            f_hold = '0;
            d_hold = '0;
            f_req_valid = 1'b1;
            d_req_valid = 1'b1;
            #1;
            chk("f_ready_in_reset", gi, 32'(f_req_ready), 32'd0);
            chk("d_ready_in_reset", gi, 32'(d_req_ready), 32'd0);
            repeat (2) @(negedge clk);
            #2;
            rst_n = 1'b1;
            f_req_valid = 1'b0;
            d_req_valid = 1'b0;
            free_at = 0;
        endtask

        // Monitor: registered outputs compared against the expectation queues.
        always @(negedge clk) begin
            if (mon_on) begin
                if (!rst_n) begin
                    chk("rst_f_rsp_valid", gi, 32'(f_rsp_valid), 32'd0);
                    chk("rst_d_rsp_valid", gi, 32'(d_rsp_valid), 32'd0);
                    chk("rst_ram_we", gi, 32'(ram_enable_write), 32'd0);
                    chk("rst_ram_adress", gi, ram_adress, 32'd0);
                    chk("rst_data_out_ram", gi, data_out_ram, 32'd0);
                    chk("rst_f_rsp_data", gi, f_rsp_data, 32'd0);
                    chk("rst_d_rsp_data", gi, d_rsp_data, 32'd0);
                end else begin
                    if (f_rsp_valid) begin
                        if (exp_f_q.size() == 0) begin
                            chk("f_rsp_unexpected", gi, 32'(f_rsp_valid), 32'd0);
                        end else begin
                            fe = exp_f_q.pop_front();
                            chk("f_rsp_cycle", gi, 32'(cyc), 32'(fe.at));
                            chk("f_rsp_data", gi, f_rsp_data, fe.data);
                            f_hold = fe.data;
                            nf++;
                        end
                    end else begin
                        if (exp_f_q.size() != 0 && exp_f_q[0].at <= cyc) begin
                            fe = exp_f_q.pop_front();
                            chk("f_rsp_missing", gi, 32'(f_rsp_valid), 32'd1);
                        end
                        chk("f_rsp_hold", gi, f_rsp_data, f_hold);
                    end
                    if (d_rsp_valid) begin
                        if (exp_d_q.size() == 0) begin
                            chk("d_rsp_unexpected", gi, 32'(d_rsp_valid), 32'd0);
                        end else begin
                            de = exp_d_q.pop_front();
                            chk("d_rsp_cycle", gi, 32'(cyc), 32'(de.at));
                            chk("d_rsp_data", gi, d_rsp_data, de.data);
                            d_hold = de.data;
                            nd++;
                        end
                    end else begin
                        if (exp_d_q.size() != 0 && exp_d_q[0].at <= cyc) begin
                            de = exp_d_q.pop_front();
                            chk("d_rsp_missing", gi, 32'(d_rsp_valid), 32'd1);
                        end
                        chk("d_rsp_hold", gi, d_rsp_data, d_hold);
                    end
                    if (ram_q.size() != 0 && cyc >= ram_q[0].at) begin
                        re = ram_q[0];
                        chk("ram_adress", gi, ram_adress, re.addr);
                        chk("ram_enable_write", gi, 32'(ram_enable_write), (cyc == re.at) ? 32'(re.we) : 32'd0);
                        if (cyc == re.at && re.we) chk("data_out_ram", gi, data_out_ram, re.wdata);
                        if (cyc >= re.at + L) ram_q.delete(0);
                    end else begin
                        chk("ram_we_idle", gi, 32'(ram_enable_write), 32'd0);
                    end
                end
            end
        end

        logic fa_acc, da_acc;
        int   nf0, nd0, grants;

        initial begin
            for (int a = 0; a < 64; a++) begin
                logic [31:0] v;
                v = $urandom;
                ram_mem[a]   = v;
                model_mem[a] = v;
            end
            ram_mem[16]   = 32'hDEADBEEF;
            model_mem[16] = 32'hDEADBEEF;

            do_reset();

            // Directed: fetch read, data write, fetch read-back of the write.
            req(1'b0, 32'h10, 1'b0, 32'h0);
            repeat (L + 4) idle();
            chk("f_read_0x10", gi, f_rsp_data, 32'hDEADBEEF);
            req(1'b1, 32'h20, 1'b1, 32'h12345678);
            repeat (L + 4) idle();
            chk("d_write_ack", gi, d_rsp_data, 32'd0);
            req(1'b0, 32'h20, 1'b0, 32'h0);
            repeat (L + 4) idle();
            chk("f_read_0x20", gi, f_rsp_data, 32'h12345678);

            // Both ports held valid from reset: strict alternation, 4 each.
            do_reset();
            nf0 = nf;
            nd0 = nd;
            grants = 0;
            for (int i = 0; i < 200 && grants < 8; i++) begin
                step(1'b1, 32'($urandom_range(0, 63)), 1'b1, 32'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)), $urandom, fa_acc, da_acc);
                grants += int'(fa_acc) + int'(da_acc);
            end
            repeat (L + 4) idle();
            chk("contention_f_rsps", gi, 32'(nf - nf0), 32'd4);
            chk("contention_d_rsps", gi, 32'(nd - nd0), 32'd4);

            // Reset during WAIT of a fetch read, then F preferred on contention.
            req(1'b0, 32'h5, 1'b0, 32'h0);
            idle();
            nf0 = nf;
            do_reset();
            step(1'b1, 32'h6, 1'b1, 32'h7, 1'b0, 32'h0, fa_acc, da_acc);
            repeat (L + 4) idle();
            chk("post_reset_f_rsps", gi, 32'(nf - nf0), 32'd1);

            // Fetch valid raised then dropped while a data read is in flight.
            nf0 = nf;
            nd0 = nd;
            req(1'b1, 32'h9, 1'b0, 32'h0);
            step(1'b1, 32'h3, 1'b0, 32'h0, 1'b0, 32'h0, fa_acc, da_acc);
            step(1'b1, 32'h3, 1'b0, 32'h0, 1'b0, 32'h0, fa_acc, da_acc);
            repeat (L + 4) idle();
            chk("dropped_f_no_rsp", gi, 32'(nf - nf0), 32'd0);
            chk("inflight_d_rsp", gi, 32'(nd - nd0), 32'd1);

            // Random traffic.
            for (int i = 0; i < 400; i++) begin
                step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)), $urandom, fa_acc, da_acc);
            end
            repeat (L + 6) idle();
            chk("f_queue_drained", gi, 32'(exp_f_q.size()), 32'd0);
            chk("d_queue_drained", gi, 32'(exp_d_q.size()), 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        fork
            begin
                wait (lane[0].done && lane[1].done);
            end
            begin
                #200000;
                errors++;
                $display("FAIL watchdog: lanes did not complete in time");
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
